apb_master_bridge: RTL and testbench

Single-outstanding APB3 initiator. Converts a valid/ready request stream from a core-side requester (debug module, DMA config port, JTAG bridge) into APB transfers, and returns read data and error status on a valid/ready response stream. Its APB port drives the slave port of the APB node, so it sits directly upstream of the node in the peripheral subsystem.

---
 rtl/apb_master_bridge.sv | 84 ++++++++
 tb/tb_apb_master_bridge.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding APB3 initiator bridging a valid/ready request stream to APB
// Ports: clk_i/rst_i (sync active-high reset); req_* request stream (valid/ready, write, addr, wdata);
// rsp_* response stream (valid/ready, rdata, err); psel/penable/pwrite/paddr/pwdata out, prdata/pready/pslverr in.
// Optional macro APB_MASTER_TIMEOUT_EN aborts ACCESS after TIMEOUT_CYCLES cycles without pready.
module apb_master_bridge #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_write_i,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [APB_DATA_WIDTH-1:0] req_wdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [APB_DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      psel_o,
  output logic                      penable_o,
  output logic                      pwrite_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [APB_DATA_WIDTH-1:0] pwdata_o,
  input  logic [APB_DATA_WIDTH-1:0] prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  localparam logic [APB_ADDR_WIDTH-1:0] MASK = APB_ADDR_WIDTH'(APB_DATA_WIDTH / 8 - 1);
  state_t state_q, state_d;
  logic accept, misaligned, timeout, done;
  assign req_ready_o = state_q == IDLE && !rsp_valid_o;
  assign accept      = req_valid_i && req_ready_o;
  assign misaligned  = |(req_addr_i & MASK);
  assign done        = state_q == ACCESS && (pready_i || timeout);
  assign psel_o      = state_q != IDLE;
  assign penable_o   = state_q == ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk_i) begin
    cnt_q <= (rst_i || state_q != ACCESS) ? '0 : pready_i ? cnt_q : cnt_q + 1'b1;
  end
  assign timeout = !pready_i && cnt_q == CW'(TIMEOUT_CYCLES - 1);
`else
  assign timeout = 1'b0 && (TIMEOUT_CYCLES < 2);
`endif
  always_comb begin
    state_d = state_q == SETUP ? ACCESS : done ? IDLE : (accept && !misaligned) ? SETUP : state_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      pwrite_o    <= 1'b0;
      paddr_o     <= '0;
      pwdata_o    <= '0;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_rdata_o <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        pwrite_o <= req_write_i;
        paddr_o  <= req_addr_i;
        pwdata_o <= req_wdata_i;
      end
      if (accept && misaligned) begin
        rsp_valid_o <= 1'b1;
        rsp_err_o   <= 1'b1;
        rsp_rdata_o <= '0;
      end else if (done) begin
        rsp_valid_o <= 1'b1;
        rsp_err_o   <= pslverr_i || !pready_i;
        rsp_rdata_o <= (!pwrite_o && pready_i && !pslverr_i) ? prdata_i : '0;
      end else if (rsp_valid_o && rsp_ready_i) begin
        rsp_valid_o <= 1'b0;
        rsp_err_o   <= 1'b0;
        rsp_rdata_o <= '0;
      end
    end
  end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: vector table, corner sequences and randomized traffic against a memory model
module tb_apb_master_bridge;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic rsp_valid, rsp_ready = 1'b1, rsp_err;
  logic [31:0] rsp_rdata;
  logic psel, penable, pwrite, pready, pslverr;
  logic [31:0] paddr, pwdata, prdata;
  int n_chk = 0, n_fail = 0;
  logic [31:0] slv_mem [64];
  logic [31:0] ref_mem [64];
  int slv_waits = 0, wcnt = 0;
  logic slv_err = 1'b0;

  apb_master_bridge #(.APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite), .paddr_o(paddr), .pwdata_o(pwdata),
    .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
  );

  assign pready  = wcnt == 0;
  assign pslverr = slv_err;
  assign prdata  = slv_mem[paddr[7:2]];

  always @(posedge clk) begin
    if (rst) begin
      wcnt <= 0;
      for (int i = 0; i < 64; i++) slv_mem[i] <= (i == 1) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | 32'(i));
    end else begin
      if (psel && !penable) wcnt <= slv_waits;
      else if (psel && penable && wcnt != 0) wcnt <= wcnt - 1;
      if (psel && penable && pready && pwrite && !pslverr) slv_mem[paddr[7:2]] <= pwdata;
    end
  end

  typedef struct {
    logic w; logic [31:0] a, d; int waits; logic e;
    logic [31:0] rd; logic er; int lat, ps, pe;
  } vec_t;
  vec_t tab [9];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic init_ref();
    for (int i = 0; i < 64; i++) ref_mem[i] = (i == 1) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | 32'(i));
  endtask

  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input int waits,
                      input logic e, output logic [31:0] rd, output logic er, output int lat,
                      output int ps, output int pe, output logic stable);
    slv_waits = waits; slv_err = e;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    step();
    req_valid = 1'b0;
    lat = 1; ps = 0; pe = 0; stable = 1'b1;
    while (!rsp_valid && lat < 60) begin
      if (psel) begin
        ps++;
        if (paddr !== a || pwrite !== w || pwdata !== d) stable = 1'b0;
      end
      if (penable) pe++;
      step();
      lat++;
    end
    rd = rsp_rdata; er = rsp_err;
    chk("idle_after_rsp", {psel, penable}, 2'b00);
    step();
  endtask

  initial begin
    logic [31:0] rd, a, d, ex_rd;
    logic er, st, w, e, ex_er, ok;
    int lat, ps, pe, idx, lo, waits, ex_lat, cyc;
    init_ref();
    tab[0] = '{1'b0, 32'h1000_0004, 32'h0, 0, 1'b0, 32'hDEAD_BEEF, 1'b0, 3, 2, 1};
    tab[1] = '{1'b1, 32'h20, 32'hA5A5_5A5A, 3, 1'b1, 32'h0, 1'b1, 6, 5, 4};
    tab[2] = '{1'b0, 32'h2, 32'h0, 0, 1'b0, 32'h0, 1'b1, 1, 0, 0};
    tab[3] = '{1'b1, 32'h40, 32'h1234_5678, 1, 1'b0, 32'h0, 1'b0, 4, 3, 2};
    tab[4] = '{1'b0, 32'h40, 32'h0, 2, 1'b0, 32'h1234_5678, 1'b0, 5, 4, 3};
    tab[5] = '{1'b0, 32'h20, 32'h0, 0, 1'b0, 32'hC0DE_0008, 1'b0, 3, 2, 1};
    tab[6] = '{1'b1, 32'h41, 32'hFFFF_FFFF, 0, 1'b0, 32'h0, 1'b1, 1, 0, 0};
    tab[7] = '{1'b0, 32'h40, 32'h0, 0, 1'b0, 32'h1234_5678, 1'b0, 3, 2, 1};
    tab[8] = '{1'b0, 32'h60, 32'h0, 0, 1'b1, 32'h0, 1'b1, 3, 2, 1};
    step(); step();
    chk("rst_psel", psel, 0); chk("rst_penable", penable, 0); chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0); chk("rst_rsp_err", rsp_err, 0); chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_apb_regs", {pwrite, paddr, pwdata}, 0);
    rst = 1'b0;
    step();
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("v%0d_req_ready", i), req_ready, 1);
      xfer(tab[i].w, tab[i].a, tab[i].d, tab[i].waits, tab[i].e, rd, er, lat, ps, pe, st);
      chk($sformatf("v%0d_rdata", i), rd, tab[i].rd);
      chk($sformatf("v%0d_err", i), er, tab[i].er);
      chk($sformatf("v%0d_latency", i), lat, tab[i].lat);
      chk($sformatf("v%0d_psel_cycles", i), ps, tab[i].ps);
      chk($sformatf("v%0d_penable_cycles", i), pe, tab[i].pe);
      chk($sformatf("v%0d_addr_data_stable", i), st, 1);
    end
    slv_waits = 0; slv_err = 1'b0; rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h44;
    step();
    req_addr = 32'h48;
    cyc = 0;
    while (!rsp_valid && cyc < 20) begin step(); cyc++; end
    chk("bp_rsp_arrives", rsp_valid, 1);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 32'hC0DE_0011 || rsp_err !== 1'b0) ok = 1'b0;
      step();
    end
    chk("bp_hold_stable", ok, 1);
    rsp_ready = 1'b1;
    step();
    chk("bp_after_hs_valid", rsp_valid, 0);
    chk("bp_after_hs_ready", req_ready, 1);
    chk("bp_after_hs_psel", psel, 0);
    step();
    req_valid = 1'b0;
    chk("bp_next_setup", {psel, penable}, 2'b10);
    cyc = 0;
    while (!rsp_valid && cyc < 20) begin step(); cyc++; end
    chk("bp_next_rdata", rsp_rdata, 32'hC0DE_0012);
    step();
    slv_waits = 100;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h4C;
    step();
    req_valid = 1'b0;
    step();
    chk("mid_in_access", {psel, penable}, 2'b11);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_psel_penable", {psel, penable}, 2'b00);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_req_ready", req_ready, 1);
    init_ref();
    step();
`ifdef APB_MASTER_TIMEOUT_EN
    xfer(1'b0, 32'h50, 32'h0, 100, 1'b0, rd, er, lat, ps, pe, st);
    chk("to_abort_err", er, 1); chk("to_abort_rdata", rd, 0);
    chk("to_abort_latency", lat, 6); chk("to_abort_penable_cycles", pe, 4);
    xfer(1'b0, 32'h50, 32'h0, 3, 1'b0, rd, er, lat, ps, pe, st);
    chk("to_last_err", er, 0); chk("to_last_rdata", rd, 32'hC0DE_0014);
    chk("to_last_latency", lat, 6);
`endif
    for (int t = 0; t < 200; t++) begin
      w = 1'($urandom_range(0, 1));
      idx = $urandom_range(0, 63);
      lo = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
      a = ($urandom & 32'hFFFF_FF00) | (32'(idx) << 2) | 32'(lo);
      d = $urandom;
      waits = $urandom_range(0, 3);
      e = ($urandom_range(0, 5) == 0);
      if (lo != 0) begin
        ex_rd = 32'h0; ex_er = 1'b1; ex_lat = 1;
      end else begin
        ex_er = e; ex_lat = 3 + waits;
        ex_rd = (!w && !e) ? ref_mem[idx] : 32'h0;
        if (w && !e) ref_mem[idx] = d;
      end
      xfer(w, a, d, waits, e, rd, er, lat, ps, pe, st);
      chk($sformatf("rnd%0d_rdata", t), rd, ex_rd);
      chk($sformatf("rnd%0d_err", t), er, ex_er);
      chk($sformatf("rnd%0d_latency", t), lat, ex_lat);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
